// File: rtl/mem_bus_arbiter.sv
// Shares one single-port synchronous memory bus between the IF and MEM stages.
// One bus cycle at a time, MEM wins ties, and read data is held until the owning stage advances.
module mem_bus_arbiter #(
   parameter int TIMEOUT_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        stallreq_if,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [3:0]  mem_sel,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        stallreq_mem,
   input  logic [5:0]  stall,
   input  logic        flush,
   output logic        bus_cyc,
   output logic        bus_stb,
   output logic        bus_we,
   output logic [3:0]  bus_sel,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        bus_timeout
);

   typedef enum logic [2:0] {
      IDLE,
      IF_BUSY,
      MEM_BUSY,
      IF_HOLD,
      MEM_HOLD
   } state_t;

   // The watchdog terminates on the last of 2^TIMEOUT_W-1 consecutive ack-less cycles.
   localparam logic [TIMEOUT_W-1:0] WDOG_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

   state_t                 state_q, state_d;
   logic                   bus_cyc_q, bus_cyc_d;
   logic                   bus_we_q, bus_we_d;
   logic [3:0]             bus_sel_q, bus_sel_d;
   logic [31:0]            bus_addr_q, bus_addr_d;
   logic [31:0]            bus_wdata_q, bus_wdata_d;
   logic [31:0]            if_rdata_q, if_rdata_d;
   logic [31:0]            mem_rdata_q, mem_rdata_d;
   logic [TIMEOUT_W-1:0]   wdog_q, wdog_d;
   logic                   flushed_q, flushed_d;
   logic                   timeout_q, timeout_d;

   logic                   flushed_now;
   logic                   term_timeout;
   logic                   terminate;
   logic                   unused_stall;

   assign unused_stall = ^{stall[5], stall[3:2], stall[0]};

   always_comb begin
      state_d      = state_q;
      bus_cyc_d    = bus_cyc_q;
      bus_we_d     = bus_we_q;
      bus_sel_d    = bus_sel_q;
      bus_addr_d   = bus_addr_q;
      bus_wdata_d  = bus_wdata_q;
      if_rdata_d   = if_rdata_q;
      mem_rdata_d  = mem_rdata_q;
      wdog_d       = wdog_q;
      flushed_d    = flushed_q;
      timeout_d    = 1'b0;
      flushed_now  = flushed_q | flush;
      term_timeout = ~bus_ack & (wdog_q == WDOG_LAST);
      terminate    = bus_ack | term_timeout;

      case (state_q)
         IDLE: begin
            if (!flush) begin
               if (mem_req) begin
                  state_d     = MEM_BUSY;
                  bus_cyc_d   = 1'b1;
                  bus_we_d    = mem_we;
                  bus_sel_d   = mem_sel;
                  bus_addr_d  = mem_addr;
                  bus_wdata_d = mem_wdata;
               end else if (if_req) begin
                  state_d     = IF_BUSY;
                  bus_cyc_d   = 1'b1;
                  bus_we_d    = 1'b0;
                  bus_sel_d   = 4'b1111;
                  bus_addr_d  = if_addr;
                  bus_wdata_d = 32'h0;
               end
            end
         end

         // A flush never aborts the bus cycle; it only marks the result for discard.
         IF_BUSY, MEM_BUSY: begin
            if (terminate) begin
               bus_cyc_d = 1'b0;
               wdog_d    = '0;
               flushed_d = 1'b0;
               timeout_d = term_timeout;
               if (flushed_now) begin
                  state_d = IDLE;
               end else if (state_q == IF_BUSY) begin
                  state_d    = IF_HOLD;
                  if_rdata_d = bus_ack ? bus_rdata : 32'h0;
               end else begin
                  state_d = MEM_HOLD;
                  if (!(bus_ack && bus_we_q)) begin
                     mem_rdata_d = bus_ack ? bus_rdata : 32'h0;
                  end
               end
            end else begin
               wdog_d    = wdog_q + 1'b1;
               flushed_d = flushed_now;
            end
         end

         IF_HOLD: begin
            if (!stall[1] || flush) begin
               state_d = IDLE;
            end
         end

         MEM_HOLD: begin
            if (!stall[4] || flush) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         bus_cyc_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_sel_q   <= 4'h0;
         bus_addr_q  <= 32'h0;
         bus_wdata_q <= 32'h0;
         if_rdata_q  <= 32'h0;
         mem_rdata_q <= 32'h0;
         wdog_q      <= '0;
         flushed_q   <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bus_cyc_q   <= bus_cyc_d;
         bus_we_q    <= bus_we_d;
         bus_sel_q   <= bus_sel_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
         wdog_q      <= wdog_d;
         flushed_q   <= flushed_d;
         timeout_q   <= timeout_d;
      end
   end

   assign bus_cyc      = bus_cyc_q;
   assign bus_stb      = bus_cyc_q;
   assign bus_we       = bus_we_q;
   assign bus_sel      = bus_sel_q;
   assign bus_addr     = bus_addr_q;
   assign bus_wdata    = bus_wdata_q;
   assign bus_timeout  = timeout_q;
   assign if_rdata     = if_rdata_q;
   assign mem_rdata    = mem_rdata_q;

   // A stage sitting in its HOLD state already has its data, so it no longer stalls.
   assign stallreq_mem = mem_req & (state_q != MEM_HOLD) & ~flush;
   assign stallreq_if  = if_req & (state_q != IF_HOLD) & ~flush;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized scoreboard bench for mem_bus_arbiter: a transaction-level model predicts bus
// cycles and held read data, while a separate monitor compares them as the DUT presents them.
module tb_mem_bus_arbiter;

   localparam int TW    = 4;
   localparam int WD    = (1 << TW) - 1;
   localparam int NEVER = 1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        stallreq_if;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_sel;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        stallreq_mem;
   logic [5:0]  stall;
   logic        flush;
   logic        flush_rsp;
   logic        flush_drv;
   logic        bus_cyc;
   logic        bus_stb;
   logic        bus_we;
   logic [3:0]  bus_sel;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;
   logic        bus_timeout;

   assign flush = flush_rsp | flush_drv;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.TIMEOUT_W(TW)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .stallreq_if(stallreq_if),
      .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stallreq_mem(stallreq_mem),
      .stall(stall), .flush(flush),
      .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_sel(bus_sel),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .bus_ack(bus_ack), .bus_timeout(bus_timeout)
   );

   typedef struct {
      bit          is_mem;
      bit          we;
      logic [3:0]  sel;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          waits;
      int          flush_at;
   } txn_t;

   typedef struct {
      bit          timeout;
      logic [31:0] if_rd;
      logic [31:0] mem_rd;
   } cmp_t;

   txn_t bus_q[$];
   txn_t plan_q[$];
   cmp_t cmp_q[$];

   int          total = 0;
   int          bad = 0;
   logic [31:0] mdl_if = 32'h0;
   logic [31:0] mdl_mem = 32'h0;
   int          st_if = 0;
   int          st_mem = 0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic failNow(input string name);
      total++;
      bad++;
      $display("[TB] FAIL %s: DUT did not respond within its bound", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Expected stall requests follow from each agent's own progress: 0 off, 1 waiting, 2 holding.
   task automatic sampleStalls();
      checkOutput("stallreq_if", stallreq_if, (st_if == 1) ? !flush : 1'b0);
      checkOutput("stallreq_mem", stallreq_mem, (st_mem == 1) ? !flush : 1'b0);
   endtask

   task automatic dropAgent(input bit is_mem);
      if (is_mem) begin
         mem_req  = 1'b0;
         stall[4] = 1'b0;
         st_mem   = 0;
      end else begin
         if_req   = 1'b0;
         stall[1] = 1'b0;
         st_if    = 0;
      end
   endtask

   task automatic resyncDut();
      if_req = 1'b0; mem_req = 1'b0; stall = 6'h0; flush_drv = 1'b0;
      st_if = 0; st_mem = 0;
      rst = 1'b1;
      bus_q.delete(); plan_q.delete(); cmp_q.delete();
      mdl_if = 32'h0; mdl_mem = 32'h0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic applyStimulus(input bit do_if, input bit do_mem, input bit mem_we_i,
                                input int w_if, input int w_mem, input int f_if, input int f_mem,
                                input int h_if, input int h_mem);
      txn_t order[$];
      txn_t t;
      cmp_t c;
      int   n;
      int   busy;
      int   term;
      int   hold;
      bit   first;
      bit   timeout;
      if (do_mem) begin
         t.is_mem = 1'b1; t.we = mem_we_i; t.sel = 4'($urandom_range(1, 15));
         t.addr = $urandom; t.wdata = $urandom; t.rdata = $urandom;
         t.waits = w_mem; t.flush_at = f_mem;
         order.push_back(t);
      end
      if (do_if) begin
         t.is_mem = 1'b0; t.we = 1'b0; t.sel = 4'hf;
         t.addr = $urandom; t.wdata = 32'h0; t.rdata = $urandom;
         t.waits = w_if; t.flush_at = f_if;
         order.push_back(t);
      end
      foreach (order[i]) begin
         t = order[i];
         bus_q.push_back(t);
         plan_q.push_back(t);
         timeout = (t.waits >= WD);
         if (t.flush_at < 0) begin
            if (!t.is_mem) mdl_if = timeout ? 32'h0 : t.rdata;
            else if (timeout) mdl_mem = 32'h0;
            else if (!t.we) mdl_mem = t.rdata;
         end
         c.timeout = timeout; c.if_rd = mdl_if; c.mem_rd = mdl_mem;
         cmp_q.push_back(c);
      end
      stall = 6'($urandom);
      stall[1] = do_if;
      stall[4] = do_mem;
      if_req = do_if; if_addr = do_if ? order[order.size()-1].addr : $urandom;
      mem_req = do_mem; mem_we = mem_we_i;
      mem_sel = do_mem ? order[0].sel : 4'h0;
      mem_addr = do_mem ? order[0].addr : $urandom;
      mem_wdata = do_mem ? order[0].wdata : $urandom;
      st_if = do_if ? 1 : 0;
      st_mem = do_mem ? 1 : 0;
      #1;
      sampleStalls();
      first = 1'b1;
      foreach (order[i]) begin
         t = order[i];
         n = 0;
         do begin
            tick();
            n++;
            sampleStalls();
         end while (!bus_cyc && n < 30);
         if (!bus_cyc) begin
            failNow("grant_wait");
            resyncDut();
            return;
         end
         checkOutput("grant_latency", n, first ? 1 : 2);
         timeout = (t.waits >= WD);
         term = timeout ? WD - 1 : t.waits;
         busy = 1;
         for (int k = 0; k < 40; k++) begin
            tick();
            if (!bus_cyc) break;
            busy++;
            sampleStalls();
         end
         if (bus_cyc) begin
            failNow("bus_end_wait");
            resyncDut();
            return;
         end
         checkOutput("busy_len", busy, term + 1);
         if (t.flush_at >= 0) begin
            sampleStalls();
            dropAgent(t.is_mem);
            first = 1'b1;
         end else begin
            if (t.is_mem) st_mem = 2; else st_if = 2;
            sampleStalls();
            hold = t.is_mem ? h_mem : h_if;
            for (int h = 0; h < hold; h++) begin
               tick();
               sampleStalls();
            end
            dropAgent(t.is_mem);
            first = 1'b0;
         end
      end
      tick();
      sampleStalls();
   endtask

   // Slave model: acks or flushes at the busy-cycle index the plan chose for each transaction.
   bit   r_active = 1'b0;
   int   r_k = 0;
   txn_t r_cur;

   initial begin
      bus_ack = 1'b0; bus_rdata = 32'h0; flush_rsp = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (bus_cyc && !rst) begin
            if (!r_active) begin
               r_active = 1'b1;
               r_k = 0;
               if (plan_q.size() > 0) begin
                  r_cur = plan_q.pop_front();
               end else begin
                  r_cur.waits = 0; r_cur.flush_at = -1; r_cur.rdata = 32'h0;
               end
            end else begin
               r_k++;
            end
            bus_ack   = (r_k == r_cur.waits);
            bus_rdata = bus_ack ? r_cur.rdata : $urandom;
            flush_rsp = (r_k == r_cur.flush_at);
         end else begin
            r_active  = 1'b0;
            bus_ack   = 1'b0;
            flush_rsp = 1'b0;
            bus_rdata = $urandom;
         end
      end
   end

   // Monitor: checks each bus cycle as it opens and the held results as it closes.
   logic        m_prev = 1'b0;
   txn_t        m_cur;
   cmp_t        m_c;
   logic [31:0] m_held_if = 32'h0;
   logic [31:0] m_held_mem = 32'h0;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            m_prev = 1'b0;
            m_held_if = 32'h0;
            m_held_mem = 32'h0;
         end else begin
            if (bus_cyc && !m_prev) begin
               if (bus_q.size() == 0) begin
                  failNow("unexpected_bus_cycle");
               end else begin
                  m_cur = bus_q.pop_front();
                  checkOutput("bus_addr", bus_addr, m_cur.addr);
                  checkOutput("bus_we", bus_we, m_cur.we);
                  checkOutput("bus_sel", bus_sel, m_cur.sel);
                  if (m_cur.we) checkOutput("bus_wdata", bus_wdata, m_cur.wdata);
               end
            end else if (bus_cyc) begin
               checkOutput("bus_stable", {bus_we, bus_sel, bus_addr}, {m_cur.we, m_cur.sel, m_cur.addr});
            end
            if (bus_cyc) checkOutput("bus_stb", bus_stb, 1'b1);
            if (!bus_cyc && m_prev) begin
               if (cmp_q.size() == 0) begin
                  failNow("unexpected_bus_end");
               end else begin
                  m_c = cmp_q.pop_front();
                  checkOutput("bus_timeout", bus_timeout, m_c.timeout);
                  checkOutput("if_rdata", if_rdata, m_c.if_rd);
                  checkOutput("mem_rdata", mem_rdata, m_c.mem_rd);
                  m_held_if = m_c.if_rd;
                  m_held_mem = m_c.mem_rd;
               end
            end else begin
               checkOutput("bus_timeout_idle", bus_timeout, 1'b0);
               checkOutput("if_rdata_held", if_rdata, m_held_if);
               checkOutput("mem_rdata_held", mem_rdata, m_held_mem);
            end
            m_prev = bus_cyc;
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] run aborted");
   end

   initial begin
      int kind;
      int w;
      int f;
      bit we;
      rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; mem_req = 1'b0; mem_we = 1'b0;
      mem_sel = 4'h0; mem_addr = 32'h0; mem_wdata = 32'h0; stall = 6'h0; flush_drv = 1'b0;
      tick(); tick(); tick();
      checkOutput("reset_cyc", {bus_cyc, bus_stb, bus_we, bus_timeout}, 4'h0);
      checkOutput("reset_bus", {bus_sel, bus_addr, bus_wdata}, 68'h0);
      checkOutput("reset_rdata", {if_rdata, mem_rdata}, 64'h0);
      rst = 1'b0;
      tick();

      applyStimulus(1, 0, 0, 0, 0, -1, -1, 2, 0);
      applyStimulus(1, 1, 1, 1, 0, -1, -1, 1, 1);
      applyStimulus(1, 0, 0, 3, 0, 1, -1, 0, 0);
      applyStimulus(0, 1, 0, 0, 1, -1, -1, 0, 4);
      applyStimulus(0, 1, 0, 0, NEVER, -1, -1, 0, 1);

      if_req = 1'b1; if_addr = $urandom; flush_drv = 1'b1;
      #1;
      checkOutput("flush_idle_stallreq", stallreq_if, 1'b0);
      tick();
      checkOutput("flush_idle_no_cycle", bus_cyc, 1'b0);
      flush_drv = 1'b0; if_req = 1'b0;
      tick();
      checkOutput("flush_idle_still_idle", bus_cyc, 1'b0);

      applyStimulus(1, 0, 0, 1, 0, -1, -1, 0, 0);
      begin
         txn_t t;
         int n;
         t.is_mem = 1'b1; t.we = 1'b0; t.sel = 4'h5; t.addr = 32'h8000_0040;
         t.wdata = 32'h0; t.rdata = 32'h0; t.waits = NEVER; t.flush_at = -1;
         bus_q.push_back(t);
         plan_q.push_back(t);
         mem_req = 1'b1; mem_we = 1'b0; mem_sel = t.sel; mem_addr = t.addr; stall[4] = 1'b1;
         n = 0;
         do begin
            tick();
            n++;
         end while (!bus_cyc && n < 10);
         tick(); tick(); tick();
         checkOutput("busy_before_reset", bus_cyc, 1'b1);
         rst = 1'b1; mem_req = 1'b0; stall = 6'h0;
         bus_q.delete(); plan_q.delete(); cmp_q.delete();
         mdl_if = 32'h0; mdl_mem = 32'h0;
         tick();
         checkOutput("midreset_cyc", {bus_cyc, bus_stb, bus_we, bus_timeout}, 4'h0);
         checkOutput("midreset_bus", {bus_sel, bus_addr}, 36'h0);
         checkOutput("midreset_rdata", {if_rdata, mem_rdata}, 64'h0);
         rst = 1'b0;
         tick();
      end

      for (int s = 0; s < 40; s++) begin
         kind = $urandom_range(0, 3);
         we = (kind == 2) || (kind == 3 && $urandom_range(0, 1) == 1);
         w = ($urandom_range(0, 7) == 0 && !(kind == 2)) ? NEVER : $urandom_range(0, 3);
         f = ($urandom_range(0, 4) == 0) ? $urandom_range(0, (w >= WD) ? WD - 1 : w) : -1;
         case (kind)
            0: applyStimulus(1, 0, 0, w, 0, f, -1, $urandom_range(0, 3), 0);
            1, 2: applyStimulus(0, 1, we, 0, w, -1, f, 0, $urandom_range(0, 3));
            default: applyStimulus(1, 1, we, $urandom_range(0, 3), we ? $urandom_range(0, 3) : w,
                                   -1, -1, $urandom_range(0, 3), $urandom_range(0, 3));
         endcase
      end

      tick(); tick();
      checkOutput("bus_q_drained", bus_q.size(), 0);
      checkOutput("cmp_q_drained", cmp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
